// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage program-counter sequencer. Each cycle it picks the
//               next fetch address from a single prioritised source:
//               stall (hold), trap vector, absolute jump, call (with push),
//               return (with pop), PC-relative branch or sequential step.
//               Return addresses live in a small circular stack. Its status
//               (occupancy and sticky overflow/underflow) goes to the control
//               unit.
// Ports       : CLOCK      rising-edge clock
//               RESET_N    asynchronous active-low reset
//               STALL      hold every register this cycle
//               TRAP       pc <- TRAP_VECTOR, epc <- pc
//               JF         pc <- target
//               CALL       pc <- target, push pc+STEP
//               RET        pc <- stack top, pop (falls through when empty)
//               BR         pc <- pc + target (target is a signed offset)
//               target     offset or absolute address, WIDTH bits
//               pc         current fetch address (registered)
//               epc        pc captured at the last accepted TRAP
//               ras_count  number of valid stack entries
//               ras_ovf    sticky: a push found the stack full
//               ras_udf    sticky: a pop found the stack empty
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter int                WIDTH        = 32,
  parameter int                STEP         = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]       TRAP_VECTOR  = 32'h0000_0100,
  // Must be a power of two and at least 2 so the top pointer wraps naturally.
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET_N,
  input  logic                          STALL,
  input  logic                          TRAP,
  input  logic                          JF,
  input  logic                          CALL,
  input  logic                          RET,
  input  logic                          BR,
  input  logic [WIDTH-1:0]              target,
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              epc,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_ovf,
  output logic                          ras_udf
);

  localparam int c_ptr_w = $clog2(RAS_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [WIDTH-1:0]   c_step    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0]   c_trap    = WIDTH'(TRAP_VECTOR);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(RAS_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // Next-pc source, one-hot in intent but binary encoded.
  localparam logic [2:0] c_sel_hold = 3'd0;
  localparam logic [2:0] c_sel_trap = 3'd1;
  localparam logic [2:0] c_sel_jump = 3'd2;
  localparam logic [2:0] c_sel_call = 3'd3;
  localparam logic [2:0] c_sel_ret  = 3'd4;
  localparam logic [2:0] c_sel_br   = 3'd5;
  localparam logic [2:0] c_sel_seq  = 3'd6;

  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_epc;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_top;
  logic               r_ovf;
  logic               r_udf;
  logic [WIDTH-1:0]   r_stack [RAS_DEPTH];

  logic [2:0]         w_sel;
  logic               w_empty;
  logic               w_full;
  logic [c_ptr_w-1:0] w_push_ptr;
  logic [WIDTH-1:0]   w_seq_pc;
  logic [WIDTH-1:0]   w_top_value;

  // Priority decode: only the highest-priority request is acted upon, the
  // rest are dropped for this cycle.
  always_comb begin
    w_sel = c_sel_seq;
    if (STALL)     w_sel = c_sel_hold;
    else if (TRAP) w_sel = c_sel_trap;
    else if (JF)   w_sel = c_sel_jump;
    else if (CALL) w_sel = c_sel_call;
    else if (RET)  w_sel = c_sel_ret;
    else if (BR)   w_sel = c_sel_br;
  end

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  // When full, top+1 lands on the oldest entry, so a push overwrites it.
  assign w_push_ptr  = r_top + c_ptr_one;
  assign w_seq_pc    = r_pc + c_step;
  // The top is read from registered state, so a pop right after a push sees
  // the pushed value with no forwarding needed.
  assign w_top_value = r_stack[r_top];

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      case (w_sel)
        c_sel_trap: begin
          r_pc  <= c_trap;
          r_epc <= r_pc;
        end
        c_sel_jump: begin
          r_pc <= target;
        end
        c_sel_call: begin
          r_pc  <= target;
          r_top <= w_push_ptr;
          if (w_full) r_ovf   <= 1'b1;
          else        r_count <= r_count + c_cnt_one;
        end
        c_sel_ret: begin
          if (w_empty) begin
            r_pc  <= w_seq_pc;
            r_udf <= 1'b1;
          end else begin
            r_pc    <= w_top_value;
            r_top   <= r_top - c_ptr_one;
            r_count <= r_count - c_cnt_one;
          end
        end
        c_sel_br: begin
          // Offset and pc share WIDTH bits, so a modulo-2^WIDTH add is the
          // same as adding the sign-extended offset.
          r_pc <= r_pc + target;
        end
        c_sel_seq: begin
          r_pc <= w_seq_pc;
        end
        default: begin
          // Stall: every register keeps its value.
        end
      endcase
    end
  end

  // Stack storage carries no reset; entries beyond ras_count are never read.
  always_ff @(posedge CLOCK) begin
    if (w_sel == c_sel_call) begin
      r_stack[w_push_ptr] <= w_seq_pc;
    end
  end

  assign pc        = r_pc;
  assign epc       = r_epc;
  assign ras_count = r_count;
  assign ras_ovf   = r_ovf;
  assign ras_udf   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Drives a 32-bit and an
//               8-bit instance from shared controls and compares both against
//               a list-based reference model, plus fixed expected values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int c_depth = 4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        STALL = 1'b0, TRAP = 1'b0, JF = 1'b0, CALL = 1'b0, RET = 1'b0, BR = 1'b0;
  logic [31:0] target = '0;

  logic [31:0] pc32, epc32;
  logic [2:0]  cnt32;
  logic        ovf32, udf32;
  logic [7:0]  pc8, epc8;
  logic [2:0]  cnt8;
  logic        ovf8, udf8;

  int n_total = 0;
  int n_bad   = 0;

  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(c_depth)) u_dut32 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .STALL(STALL), .TRAP(TRAP), .JF(JF),
    .CALL(CALL), .RET(RET), .BR(BR), .target(target),
    .pc(pc32), .epc(epc32), .ras_count(cnt32), .ras_ovf(ovf32), .ras_udf(udf32)
  );

  pc_sequencer #(.WIDTH(8), .RAS_DEPTH(c_depth)) u_dut8 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .STALL(STALL), .TRAP(TRAP), .JF(JF),
    .CALL(CALL), .RET(RET), .BR(BR), .target(target[7:0]),
    .pc(pc8), .epc(epc8), .ras_count(cnt8), .ras_ovf(ovf8), .ras_udf(udf8)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: index 0 is the 32-bit instance, index 1 the 8-bit one.
  // The stack is a plain list, oldest entry first.
  int              m_w [2] = '{32, 8};
  longint unsigned m_pc  [2];
  longint unsigned m_epc [2];
  int              m_cnt [2];
  bit              m_ovf [2];
  bit              m_udf [2];
  longint unsigned m_stk [2][c_depth];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_epc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit s, input bit t, input bit j,
                            input bit c, input bit r, input bit b,
                            input longint unsigned tg);
    longint unsigned mask, tv, off;
    mask = (64'd1 << m_w[k]) - 1;
    tv   = tg & mask;
    if (s) begin
    end else if (t) begin
      m_epc[k] = m_pc[k];
      m_pc[k]  = 64'h100 & mask;
    end else if (j) begin
      m_pc[k] = tv;
    end else if (c) begin
      if (m_cnt[k] == c_depth) begin
        for (int i = 0; i < c_depth - 1; i++) m_stk[k][i] = m_stk[k][i+1];
        m_stk[k][c_depth-1] = (m_pc[k] + 4) & mask;
        m_ovf[k] = 1;
      end else begin
        m_stk[k][m_cnt[k]] = (m_pc[k] + 4) & mask;
        m_cnt[k]++;
      end
      m_pc[k] = tv;
    end else if (r) begin
      if (m_cnt[k] == 0) begin
        m_udf[k] = 1;
        m_pc[k]  = (m_pc[k] + 4) & mask;
      end else begin
        m_cnt[k]--;
        m_pc[k] = m_stk[k][m_cnt[k]];
      end
    end else if (b) begin
      off = tv;
      if (((tv >> (m_w[k] - 1)) & 1) != 0) off = tv | ~mask;
      m_pc[k] = (m_pc[k] + off) & mask;
    end else begin
      m_pc[k] = (m_pc[k] + 4) & mask;
    end
  endtask

  task automatic compare_all();
    check_value("pc32",  {32'h0, pc32},  m_pc[0]);
    check_value("epc32", {32'h0, epc32}, m_epc[0]);
    check_value("cnt32", {61'h0, cnt32}, 64'(m_cnt[0]));
    check_value("ovf32", {63'h0, ovf32}, {63'h0, m_ovf[0]});
    check_value("udf32", {63'h0, udf32}, {63'h0, m_udf[0]});
    check_value("pc8",   {56'h0, pc8},   m_pc[1]);
    check_value("epc8",  {56'h0, epc8},  m_epc[1]);
    check_value("cnt8",  {61'h0, cnt8},  64'(m_cnt[1]));
    check_value("ovf8",  {63'h0, ovf8},  {63'h0, m_ovf[1]});
    check_value("udf8",  {63'h0, udf8},  {63'h0, m_udf[1]});
  endtask

  // Apply one set of requests, let one edge pass, then compare.
  task automatic cycle(input bit s, input bit t, input bit j, input bit c,
                       input bit r, input bit b, input logic [31:0] tg);
    STALL = s; TRAP = t; JF = j; CALL = c; RET = r; BR = b; target = tg;
    @(posedge CLOCK);
    for (int k = 0; k < 2; k++) model_step(k, s, t, j, c, r, b, 64'(tg));
    #1;
    compare_all();
  endtask

  task automatic idle();      cycle(0, 0, 0, 0, 0, 0, 32'h0); endtask
  task automatic jump(input logic [31:0] a); cycle(0, 0, 1, 0, 0, 0, a); endtask
  task automatic call(input logic [31:0] a); cycle(0, 0, 0, 1, 0, 0, a); endtask
  task automatic ret();       cycle(0, 0, 0, 0, 1, 0, 32'h0); endtask
  task automatic branch(input logic [31:0] o); cycle(0, 0, 0, 0, 0, 1, o); endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    check_value("reset_pc", {32'h0, pc32}, 64'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Free run from the reset vector.
    idle(); check_value("run_4",  {32'h0, pc32}, 64'h4);
    idle(); check_value("run_8",  {32'h0, pc32}, 64'h8);
    idle(); check_value("run_12", {32'h0, pc32}, 64'hC);

    // Reset pulse between edges takes effect at once.
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check_value("async_rst_pc", {32'h0, pc32}, 64'h0);
    compare_all();
    #1 RESET_N = 1'b1;
    idle(); check_value("after_rst", {32'h0, pc32}, 64'h4);

    // Relative branch and absolute jump.
    jump(32'h40);
    branch(32'hFFFF_FFF8); check_value("br_neg8", {32'h0, pc32}, 64'h38);
    jump(32'h1000);        check_value("jf_1000", {32'h0, pc32}, 64'h1000);

    // Nested call / return.
    jump(32'h100);
    call(32'h2000); check_value("call1_pc", {32'h0, pc32}, 64'h2000);
                    check_value("call1_cnt", {61'h0, cnt32}, 64'h1);
    call(32'h3000); check_value("call2_pc", {32'h0, pc32}, 64'h3000);
                    check_value("call2_cnt", {61'h0, cnt32}, 64'h2);
    ret();          check_value("ret1_pc", {32'h0, pc32}, 64'h2004);
    ret();          check_value("ret2_pc", {32'h0, pc32}, 64'h104);
                    check_value("ret2_cnt", {61'h0, cnt32}, 64'h0);

    // Overflow then underflow.
    for (int i = 1; i <= 5; i++) call(32'(i) * 32'h1000);
    check_value("ovf_flag", {63'h0, ovf32}, 64'h1);
    check_value("ovf_cnt",  {61'h0, cnt32}, 64'h4);
    ret(); check_value("pop_a", {32'h0, pc32}, 64'h4004);
    ret(); check_value("pop_b", {32'h0, pc32}, 64'h3004);
    ret(); check_value("pop_c", {32'h0, pc32}, 64'h2004);
    ret(); check_value("pop_d", {32'h0, pc32}, 64'h1004);
    check_value("udf_before", {63'h0, udf32}, 64'h0);
    ret(); check_value("pop_empty_pc", {32'h0, pc32}, 64'h1008);
    check_value("udf_flag", {63'h0, udf32}, 64'h1);

    // Collisions: trap wins over call; stall wins over everything.
    call(32'h200);
    cycle(0, 1, 0, 1, 0, 0, 32'h5555);
    check_value("trap_pc",  {32'h0, pc32},  64'h100);
    check_value("trap_epc", {32'h0, epc32}, 64'h200);
    check_value("trap_cnt", {61'h0, cnt32}, 64'h1);
    cycle(1, 1, 0, 1, 0, 0, 32'h7777);
    check_value("stall_pc",  {32'h0, pc32},  64'h100);
    check_value("stall_epc", {32'h0, epc32}, 64'h200);
    check_value("stall_cnt", {61'h0, cnt32}, 64'h1);

    // Wrap on the 8-bit instance.
    jump(32'hFC);
    idle();         check_value("wrap8_inc", {56'h0, pc8}, 64'h00);
    jump(32'h90);
    branch(32'h7F); check_value("wrap8_br",  {56'h0, pc8}, 64'h0F);

    // Randomised traffic with frequent request collisions.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tg;
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       tg = $urandom;
        1:       tg = 32'($signed(int'($urandom_range(0, 64)) - 32));
        default: tg = $urandom_range(0, 255);
      endcase
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, tg);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer that replaces the fixed 32-bit accumulate-or-load counter in the fetch stage. Each cycle it selects the next fetch address from one of several sources: sequential increment, PC-relative branch, absolute jump, call and return through an internal return-address stack, or a trap vector. It drives the fetch address and captures the exception PC. It also reports stack status to the control unit.

## Interface
Parameters:
- WIDTH, 32, address/offset width in bits
- STEP, 4, sequential increment added when no redirect is taken
- RESET_VECTOR, 0, pc value at reset
- TRAP_VECTOR, 32'h0000_0100, pc loaded on TRAP (truncated to WIDTH)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- STALL  in  1  hold all state this cycle
- TRAP  in  1  redirect to TRAP_VECTOR, capture epc
- JF  in  1  absolute jump: pc ← target
- CALL  in  1  absolute call: pc ← target, push pc+STEP
- RET  in  1  return: pc ← stack top, pop
- BR  in  1  relative branch: pc ← pc+target
- target  in  WIDTH  signed offset (BR) or absolute address (JF/CALL)
- pc  out  WIDTH  current fetch address (registered)
- epc  out  WIDTH  pc at the last accepted TRAP
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries
- ras_ovf  out  1  sticky: a push found the stack full
- ras_udf  out  1  sticky: a pop found the stack empty

## Operation
- Reset (RESET_N=0, asynchronous):
  - pc=RESET_VECTOR, epc=0, ras_count=0, ras_ovf=0, ras_udf=0.
  - Stack contents are don't-care.
- Per rising edge, priority order. Exactly one action is taken.
  1. STALL=1: nothing changes, including the stack and flags.
  2. TRAP: pc←TRAP_VECTOR, epc←pc. Stack unchanged.
  3. JF: pc←target.
  4. CALL: pc←target; push pc+STEP.
  5. RET: pc←top entry; pop.
  6. BR: pc←pc+target, with target sign-extended, not zero-extended.
  7. Otherwise pc←pc+STEP.
- All arithmetic is modulo 2^WIDTH. Wrap past all-ones is silent.
- Stack is circular storage with a top pointer.
  - Push when full (ras_count==RAS_DEPTH):
    - Overwrites the oldest entry.
    - ras_count stays RAS_DEPTH.
    - ras_ovf←1.
  - Pop when empty (ras_count==0):
    - pc←pc+STEP (falls through).
    - ras_count stays 0.
    - ras_udf←1.
  - ras_ovf and ras_udf clear only on reset.
- Lower-priority requests asserted in the same cycle are dropped, not queued. Example: CALL+RET together performs CALL only.

## Timing
- Latency is one cycle. A request sampled at edge N produces the new pc after edge N.
- epc, ras_count and the flags update on the same edge as pc.
- A push followed by a pop on the next cycle returns exactly the pushed value. No bypass hazard exists, because the top is read from registered state.
- Reset assertion mid-operation takes effect immediately, without waiting for a clock edge.
- Release is synchronous to the next CLOCK edge. The first edge after release applies normal operation from RESET_VECTOR.
- Inputs need only be stable around the rising edge. No internal pipeline beyond the pc/stack registers.

## Test plan
- Reset then free-run, WIDTH=32, STEP=4, RESET_VECTOR=0 → pc reads 0, 4, 8, 12. Pulse RESET_N low mid-cycle → pc=0 immediately.
- Starting at pc=0x40:
  - BR with target=-8 → pc=0x38.
  - JF with target=0x1000 → pc=0x1000.
- Call/return sequence:
  - From pc=0x100: CALL target=0x2000 → pc=0x2000, ras_count=1.
  - From pc=0x2000: CALL target=0x3000 → pc=0x3000, ras_count=2.
  - RET → pc=0x2004. RET → pc=0x104, ras_count=0.
- RAS_DEPTH=4, five nested CALLs → ras_ovf=1, ras_count=4. Five RETs:
  - First four return the four newest return addresses.
  - Fifth gives pc=prev+4 and sets ras_udf=1.
- Collision cases:
  - TRAP+CALL+STALL=0 at pc=0x200 → pc=0x100, epc=0x200, ras_count unchanged.
  - Repeat with STALL=1 → pc, epc and stack all unchanged.
- Wrap, WIDTH=8, pc=0xFC → increment gives 0x00. BR with target=0x7F from 0x90 → pc=0x0F.
